// File: rtl/audio_sched_pkg.sv
// Shared types and helpers for the sound-effect scheduler.
// Holds the slot FSM state type, register map constants and the output saturation helper.
package audio_sched_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [2:0] REG_VOL  = 3'd6;
    localparam logic [2:0] REG_CTRL = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT
    } state_t;

    // Clamp the wide accumulator to the signed sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W+2:0] acc);
        logic signed [SAMPLE_W+2:0] max_v;
        logic signed [SAMPLE_W+2:0] min_v;
        max_v = {4'b0000, {(SAMPLE_W-1){1'b1}}};
        min_v = {4'b1111, {(SAMPLE_W-1){1'b0}}};
        if (acc > max_v) begin
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (acc < min_v) begin
            return {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            return acc[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sfx_voice.sv
// One playback voice: remembers its programmed start/length/loop and walks a
// sample pointer through the ROM each time the scheduler fetches for it.
// A load has priority over a stop, and a stop over an advance.
module sfx_voice #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_start,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              load_loop,
    input  logic              stop,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr,
    output logic              active
);

    logic [ADDR_W-1:0] start_q, start_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              active_q, active_d;

    // Next-state of the voice: reprogram, stop, or step to the next sample.
    always_comb begin
        start_d  = start_q;
        len_d    = len_q;
        loop_d   = loop_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        active_d = active_q;
        if (load) begin
            start_d  = load_start;
            len_d    = load_len;
            loop_d   = load_loop;
            ptr_d    = load_start;
            rem_d    = load_len;
            active_d = (load_len != '0);
        end else if (stop) begin
            active_d = 1'b0;
        end else if (advance && active_q) begin
            if (rem_q == LEN_W'(1)) begin
                if (loop_q) begin
                    ptr_d = start_q;
                    rem_d = len_q;
                end else begin
                    ptr_d    = ptr_q + ADDR_W'(1);
                    rem_d    = '0;
                    active_d = 1'b0;
                end
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
                rem_d = rem_q - LEN_W'(1);
            end
        end
    end

    // Voice state registers with synchronous reset to an idle, inactive voice.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q  <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            ptr_q    <= '0;
            rem_q    <= '0;
            active_q <= 1'b0;
        end else begin
            start_q  <= start_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            active_q <= active_d;
        end
    end

    assign ptr    = ptr_q;
    assign active = active_q;

endmodule

// File: rtl/audio_sfx_scheduler.sv
// Sound-effect scheduler: per sample slot, fetches one ROM sample per voice
// round-robin, sums them with saturation and offers the mono mix to both sinks.
// Optional per-voice attenuation is enabled by defining AUDIO_SCHED_VOLUME_EN.
module audio_sfx_scheduler
    import audio_sched_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 16,
    parameter int SAMPLE_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [2:0]          address,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_rdata,
    input  logic                l_ready,
    output logic                l_valid,
    output logic [SAMPLE_W-1:0] l_data,
    input  logic                r_ready,
    output logic                r_valid,
    output logic [SAMPLE_W-1:0] r_data
);

    localparam int         ACC_W    = SAMPLE_W + 3;
    localparam int         VOL_W    = 4 * NUM_VOICES;
    localparam logic [2:0] LAST_IDX = 3'(NUM_VOICES - 1);

    logic wr_en;
    logic rd_en;
    assign wr_en = chipselect && write;
    assign rd_en = chipselect && read;

    state_t                     state_q, state_d;
    logic [2:0]                 idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       pend_valid_q, pend_valid_d;
    logic [2:0]                 pend_idx_q, pend_idx_d;
    logic                       l_valid_q, l_valid_d;
    logic                       r_valid_q, r_valid_d;
    logic [SAMPLE_W-1:0]        out_data_q, out_data_d;

    logic [ADDR_W-1:0]          v_ptr [NUM_VOICES];
    logic [NUM_VOICES-1:0]      v_active;
    logic [NUM_VOICES-1:0]      v_load;
    logic [NUM_VOICES-1:0]      v_stop;
    logic [NUM_VOICES-1:0]      v_advance;

    logic [ADDR_W-1:0]          sel_ptr;
    logic                       sel_active;
    logic [3:0]                 shift_amt;
    logic signed [SAMPLE_W-1:0] sample_shifted;
    logic signed [ACC_W-1:0]    add_term;
    logic signed [ACC_W-1:0]    acc_sum;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign v_load[v]    = wr_en && (address == 3'(v));
        assign v_stop[v]    = wr_en && (address == REG_CTRL) && writedata[v];
        assign v_advance[v] = (state_q == FETCH) && (idx_q == 3'(v)) && !v_load[v];

        sfx_voice #(
            .ADDR_W (ADDR_W),
            .LEN_W  (15)
        ) u_voice (
            .clk        (clk),
            .reset      (reset),
            .load       (v_load[v]),
            .load_start (writedata[ADDR_W-1:0]),
            .load_len   (writedata[30:16]),
            .load_loop  (writedata[31]),
            .stop       (v_stop[v]),
            .advance    (v_advance[v]),
            .ptr        (v_ptr[v]),
            .active     (v_active[v])
        );
    end

`ifdef AUDIO_SCHED_VOLUME_EN
    logic [VOL_W-1:0] vol_q, vol_d;

    // Attenuation register, rewritten as a whole by a volume write.
    always_comb begin
        vol_d = vol_q;
        if (wr_en && (address == REG_VOL)) begin
            vol_d = writedata[VOL_W-1:0];
        end
    end

    // Attenuation storage, cleared to full volume on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vol_q <= '0;
        end else begin
            vol_q <= vol_d;
        end
    end

    // Pick the attenuation of the voice whose sample is arriving this cycle.
    always_comb begin
        shift_amt = 4'd0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (pend_idx_q == 3'(v)) begin
                shift_amt = vol_q[4*v +: 4];
            end
        end
    end
`else
    assign shift_amt = 4'd0;
`endif

    // Select the pointer and activity of the voice owning the current fetch slot.
    always_comb begin
        sel_ptr    = '0;
        sel_active = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (idx_q == 3'(v)) begin
                sel_ptr    = v_ptr[v];
                sel_active = v_active[v];
            end
        end
    end

    assign sample_shifted = $signed(rom_rdata) >>> shift_amt;
    assign add_term       = pend_valid_q ? {{3{sample_shifted[SAMPLE_W-1]}}, sample_shifted} : '0;
    assign acc_sum        = acc_q + add_term;
    assign rom_addr       = (state_q == FETCH) ? sel_ptr : '0;

    // Slot sequencing: wait for both sinks, fetch every voice, finish the sum, then hand off.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        pend_valid_d = 1'b0;
        pend_idx_d   = pend_idx_q;
        l_valid_d    = l_valid_q;
        r_valid_d    = r_valid_q;
        out_data_d   = out_data_q;
        unique case (state_q)
            IDLE: begin
                acc_d = '0;
                if (l_ready && r_ready) begin
                    state_d = FETCH;
                    idx_d   = 3'd0;
                end
            end
            FETCH: begin
                acc_d        = acc_sum;
                pend_valid_d = sel_active;
                pend_idx_d   = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DRAIN: begin
                acc_d      = acc_sum;
                out_data_d = sat16(acc_sum);
                l_valid_d  = 1'b1;
                r_valid_d  = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                if (l_valid_q && l_ready) begin
                    l_valid_d = 1'b0;
                end
                if (r_valid_q && r_ready) begin
                    r_valid_d = 1'b0;
                end
                if (!l_valid_d && !r_valid_d) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slot FSM and registered sink outputs; reset abandons any partial slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            l_valid_q    <= 1'b0;
            r_valid_q    <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            l_valid_q    <= l_valid_d;
            r_valid_q    <= r_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // Register readback: active mask, and attenuation when that feature is built in.
    always_comb begin
        readdata = '0;
        if (rd_en) begin
            case (address)
                REG_CTRL: readdata[NUM_VOICES-1:0] = v_active;
`ifdef AUDIO_SCHED_VOLUME_EN
                REG_VOL:  readdata[VOL_W-1:0] = vol_q;
`endif
                default:  readdata = '0;
            endcase
        end
    end

    assign l_valid = l_valid_q;
    assign r_valid = r_valid_q;
    assign l_data  = out_data_q;
    assign r_data  = out_data_q;

endmodule
